// File: rtl/garage_door_ctrl.sv
// -----------------------------------------------------------------------------
// garage_door_ctrl
//
// Moore state machine that sequences the garage door motor from a one-cycle
// button pulse. It watches the open/closed limit switches and the obstruction
// beam, enforces a travel timeout and runs a courtesy light that stays on for
// a fixed time after the door stops moving.
//
// Ports
//   Clk          in   1  system clock, all logic on the rising edge
//   Rst          in   1  synchronous, active-high reset
//   BtnPulse     in   1  one-cycle button press pulse (already synchronised)
//   LimitOpen    in   1  1 = door fully open
//   LimitClosed  in   1  1 = door fully closed
//   Obstruct     in   1  1 = safety beam broken
//   MotorUp      out  1  motor raise enable (only while OPENING)
//   MotorDown    out  1  motor lower enable (only while CLOSING)
//   Light        out  1  courtesy light
//   DoorState    out  3  current state code
//
// Parameters
//   TRAVEL_MAX    cycles of motor travel allowed before FAULT
//   LIGHT_CYCLES  cycles the light stays on after motion stops
// -----------------------------------------------------------------------------
module garage_door_ctrl #(
    parameter int unsigned TRAVEL_MAX   = 32'd500_000_000,
    parameter int unsigned LIGHT_CYCLES = 32'd250_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       BtnPulse,
    input  logic       LimitOpen,
    input  logic       LimitClosed,
    input  logic       Obstruct,
    output logic       MotorUp,
    output logic       MotorDown,
    output logic       Light,
    output logic [2:0] DoorState
);

    localparam int TW = $clog2(TRAVEL_MAX + 32'd1);
    localparam int LW = $clog2(LIGHT_CYCLES + 32'd1);

    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_MAX - 32'd1);
    localparam logic [TW-1:0] TRAVEL_SAT  = TW'(TRAVEL_MAX);
    localparam logic [TW-1:0] TRAVEL_ONE  = TW'(32'd1);
    localparam logic [TW-1:0] TRAVEL_ZERO = TW'(32'd0);
    localparam logic [LW-1:0] LIGHT_LOAD  = LW'(LIGHT_CYCLES);
    localparam logic [LW-1:0] LIGHT_ONE   = LW'(32'd1);
    localparam logic [LW-1:0] LIGHT_ZERO  = LW'(32'd0);

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_STOP_UP = 3'd4,
        ST_STOP_DN = 3'd5,
        ST_FAULT   = 3'd6
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   travel_q, travel_d;
    logic [LW-1:0]   light_cnt_q, light_cnt_d;
    logic            motor_up_q, motor_up_d;
    logic            motor_down_q, motor_down_d;
    logic            light_q, light_d;

    logic            moving_s;
    logic            next_moving_s;
    logic            timeout_s;

    // Next-state logic; within each state the checks are ordered
    // limit > obstruction > timeout > button.
    always_comb begin
        state_d   = state_q;
        moving_s  = (state_q == ST_OPENING) || (state_q == ST_CLOSING);
        timeout_s = moving_s && (travel_q == TRAVEL_LAST);
        case (state_q)
            ST_CLOSED: begin
                if (BtnPulse) begin
                    state_d = ST_OPENING;
                end else begin
                    state_d = ST_CLOSED;
                end
            end
            ST_OPENING: begin
                // The beam is deliberately not consulted while raising.
                if (LimitOpen) begin
                    state_d = ST_OPEN;
                end else if (timeout_s) begin
                    state_d = ST_FAULT;
                end else if (BtnPulse) begin
                    state_d = ST_STOP_UP;
                end else begin
                    state_d = ST_OPENING;
                end
            end
            ST_OPEN: begin
                if (BtnPulse && !Obstruct) begin
                    state_d = ST_CLOSING;
                end else begin
                    state_d = ST_OPEN;
                end
            end
            ST_CLOSING: begin
                if (LimitClosed) begin
                    state_d = ST_CLOSED;
                end else if (Obstruct) begin
                    state_d = ST_OPENING;
                end else if (timeout_s) begin
                    state_d = ST_FAULT;
                end else if (BtnPulse) begin
                    state_d = ST_STOP_DN;
                end else begin
                    state_d = ST_CLOSING;
                end
            end
            ST_STOP_UP: begin
                if (BtnPulse && !Obstruct) begin
                    state_d = ST_CLOSING;
                end else begin
                    state_d = ST_STOP_UP;
                end
            end
            ST_STOP_DN: begin
                if (BtnPulse) begin
                    state_d = ST_OPENING;
                end else begin
                    state_d = ST_STOP_DN;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                // Unused code 7 is treated as a corrupted state.
                state_d = ST_FAULT;
            end
        endcase
    end

    // Travel and light counters plus output decode of the next state, so the
    // registered outputs always match the state register.
    always_comb begin
        next_moving_s = (state_d == ST_OPENING) || (state_d == ST_CLOSING);

        // A new movement (including a reversal) starts timing from zero.
        if (next_moving_s && (state_d != state_q)) begin
            travel_d = TRAVEL_ZERO;
        end else if (moving_s) begin
            if (travel_q == TRAVEL_SAT) begin
                travel_d = travel_q;
            end else begin
                travel_d = travel_q + TRAVEL_ONE;
            end
        end else begin
            travel_d = travel_q;
        end

        // The countdown only runs after motion stops somewhere other than FAULT.
        if (next_moving_s || (state_d == ST_FAULT)) begin
            light_cnt_d = LIGHT_ZERO;
        end else if (moving_s) begin
            light_cnt_d = LIGHT_LOAD;
        end else if (light_cnt_q != LIGHT_ZERO) begin
            light_cnt_d = light_cnt_q - LIGHT_ONE;
        end else begin
            light_cnt_d = LIGHT_ZERO;
        end

        motor_up_d   = (state_d == ST_OPENING);
        motor_down_d = (state_d == ST_CLOSING);
        light_d      = next_moving_s || (state_d == ST_FAULT) ||
                       (light_cnt_d != LIGHT_ZERO);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_CLOSED;
            travel_q     <= TRAVEL_ZERO;
            light_cnt_q  <= LIGHT_ZERO;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            light_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            travel_q     <= travel_d;
            light_cnt_q  <= light_cnt_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            light_q      <= light_d;
        end
    end

    assign MotorUp   = motor_up_q;
    assign MotorDown = motor_down_q;
    assign Light     = light_q;
    assign DoorState = state_q;

endmodule

// File: tb/tb_garage_door_ctrl.sv
// -----------------------------------------------------------------------------
// tb_garage_door_ctrl
//
// Directed scenarios followed by randomized stimulus. A reference model kept
// in terms of edge timestamps (when motion started, until when the light
// stays lit) predicts the door state and outputs after every clock edge.
// -----------------------------------------------------------------------------
module tb_garage_door_ctrl;

    localparam int TM = 20;
    localparam int LC = 10;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       lim_open;
    logic       lim_closed;
    logic       obstruct;
    logic       motor_up;
    logic       motor_down;
    logic       light;
    logic [2:0] door_state;

    int n_checks;
    int n_pass;

    // reference model
    int m_state;
    int cyc;
    int start_cyc;
    int light_until;

    garage_door_ctrl #(
        .TRAVEL_MAX   (TM),
        .LIGHT_CYCLES (LC)
    ) dut (
        .Clk         (clk),
        .Rst         (rst),
        .BtnPulse    (btn),
        .LimitOpen   (lim_open),
        .LimitClosed (lim_closed),
        .Obstruct    (obstruct),
        .MotorUp     (motor_up),
        .MotorDown   (motor_down),
        .Light       (light),
        .DoorState   (door_state)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic bit is_moving(input int s);
        return (s == 1) || (s == 3);
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_edge();
        int  nxt;
        bit  mov;
        bit  tmo;
        if (rst) begin
            m_state     = 0;
            light_until = 0;
            start_cyc   = cyc;
        end else begin
            mov = is_moving(m_state);
            tmo = mov && ((cyc - start_cyc) == TM - 1);
            nxt = m_state;
            case (m_state)
                0: if (btn) nxt = 1;
                1: begin
                    if (lim_open) nxt = 2;
                    else if (tmo) nxt = 6;
                    else if (btn) nxt = 4;
                end
                2: if (btn && !obstruct) nxt = 3;
                3: begin
                    if (lim_closed) nxt = 0;
                    else if (obstruct) nxt = 1;
                    else if (tmo) nxt = 6;
                    else if (btn) nxt = 5;
                end
                4: if (btn && !obstruct) nxt = 3;
                5: if (btn) nxt = 1;
                default: nxt = 6;
            endcase
            if (is_moving(nxt) && nxt != m_state) start_cyc = cyc + 1;
            if (is_moving(nxt) || nxt == 6) light_until = 0;
            else if (mov) light_until = cyc + 1 + LC;
            m_state = nxt;
        end
        cyc++;
    endtask

    // One clock: model follows the rising edge, outputs compared on the falling edge.
    task automatic cycle();
        logic [5:0] exp_v;
        logic       exp_light;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        exp_light = is_moving(m_state) || (m_state == 6) || (cyc < light_until);
        exp_v = {m_state[2:0], m_state == 1, m_state == 3, exp_light};
        check("outputs", {26'd0, door_state, motor_up, motor_down, light}, {26'd0, exp_v});
    endtask

    task automatic drive(input logic b, input logic lo, input logic lcl, input logic ob, input logic r);
        btn        = b;
        lim_open   = lo;
        lim_closed = lcl;
        obstruct   = ob;
        rst        = r;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int up_cycles;
        n_checks    = 0;
        n_pass      = 0;
        m_state     = 0;
        cyc         = 0;
        start_cyc   = 0;
        light_until = 0;
        btn = 1'b0; lim_open = 1'b0; lim_closed = 1'b0; obstruct = 1'b0; rst = 1'b1;

        // 1: reset, open with limit arriving after five cycles of travel
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_state", {29'd0, door_state}, 32'd0);
        check("reset_light", {31'd0, light}, 32'd0);
        up_cycles = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        if (motor_up) up_cycles++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (motor_up) up_cycles++;
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        if (motor_up) up_cycles++;
        check("open_state", {29'd0, door_state}, 32'd2);
        check("up_cycles", up_cycles, 32'd5);
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("light_hold", {31'd0, light}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("light_off", {31'd0, light}, 32'd0);

        // 2: close, obstruction on the third cycle reverses with a fresh timer
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("closing", {29'd0, door_state}, 32'd3);
        idle(2);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("reverse", {30'd0, motor_up, motor_down}, 32'd2);
        idle(19);
        check("rev_pre_tmo", {29'd0, door_state}, 32'd1);
        idle(1);
        check("rev_timeout", {29'd0, door_state}, 32'd6);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // 3: stop while opening, then the next press closes
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stop_up", {26'd0, door_state, motor_up, motor_down, 1'b0}, {26'd0, 3'd4, 3'd0});
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stop_up_close", {31'd0, motor_down}, 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("closed_limit", {29'd0, door_state}, 32'd0);

        // 4: closing with no limit times out; button ignored in FAULT
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(20);
        check("fault", {26'd0, door_state, motor_up, motor_down, light}, {26'd0, 3'd6, 3'd1});
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("fault_sticky", {29'd0, door_state}, 32'd6);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("fault_reset", {29'd0, door_state}, 32'd0);

        // 5: limit beats obstruction and button on the same edge
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("limit_wins", {29'd0, door_state}, 32'd0);

        // 6: reset while opening
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_travel", {26'd0, door_state, motor_up, motor_down, light}, 32'd0);

        // randomized stimulus
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 249) == 0));
            if (motor_up && motor_down) check("exclusive", 32'd1, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
